// File: rtl/i3c_phy_pkg.sv
// rtl/i3c_phy_pkg.sv - shared types for the I3C PHY push-pull driver controller
package i3c_phy_pkg;

  typedef enum logic [1:0] {
    DrvOff  = 2'd0,
    DrvHigh = 2'd1,
    DrvLow  = 2'd2,
    DrvGap  = 2'd3
  } drv_state_e;

  typedef enum logic [1:0] {
    TgtOff  = 2'd0,
    TgtHigh = 2'd1,
    TgtLow  = 2'd2
  } drv_tgt_e;

endpackage

// File: rtl/phy_pp_drv_ctrl.sv
// rtl/phy_pp_drv_ctrl.sv - push-pull driver enable sequencer with break-before-make gap
module phy_pp_drv_ctrl
  import i3c_phy_pkg::*;
#(
  parameter int DeadTimeW = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 drive_en_i,
  input  logic                 data_i,
  input  logic                 od_mode_i,
  input  logic [DeadTimeW-1:0] dead_cycles_i,
  output logic                 pull_up_en_o,
  output logic                 pull_down_en_o,
  output logic                 busy_o
);

  drv_tgt_e             tgt;
  drv_state_e           state_q, state_d;
  logic [DeadTimeW-1:0] cnt_q, cnt_d;

  // Open-drain high means release: only the pull-down is ever driven in that mode.
  always_comb begin
    tgt = TgtOff;
    if (drive_en_i) begin
      if (!data_i)         tgt = TgtLow;
      else if (!od_mode_i) tgt = TgtHigh;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      DrvOff: begin
        if (tgt == TgtHigh)     state_d = DrvHigh;
        else if (tgt == TgtLow) state_d = DrvLow;
      end
      DrvHigh: begin
        if (tgt == TgtOff) state_d = DrvOff;
        else if (tgt == TgtLow) begin
          if (dead_cycles_i == '0) state_d = DrvLow;
          else begin
            state_d = DrvGap;
            cnt_d   = dead_cycles_i - DeadTimeW'(1);
          end
        end
      end
      DrvLow: begin
        if (tgt == TgtOff) state_d = DrvOff;
        else if (tgt == TgtHigh) begin
          if (dead_cycles_i == '0) state_d = DrvHigh;
          else begin
            state_d = DrvGap;
            cnt_d   = dead_cycles_i - DeadTimeW'(1);
          end
        end
      end
      DrvGap: begin
        // The gap always runs to completion; only a release cuts it short.
        if (tgt == TgtOff) begin
          state_d = DrvOff;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DeadTimeW'(1);
        end else begin
          state_d = (tgt == TgtHigh) ? DrvHigh : DrvLow;
        end
      end
      default: state_d = DrvOff;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= DrvOff;
      cnt_q          <= '0;
      pull_up_en_o   <= 1'b0;
      pull_down_en_o <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      case (state_d)
        DrvHigh: begin pull_up_en_o <= 1'b1; pull_down_en_o <= 1'b0; busy_o <= 1'b0; end
        DrvLow:  begin pull_up_en_o <= 1'b0; pull_down_en_o <= 1'b1; busy_o <= 1'b0; end
        DrvGap:  begin pull_up_en_o <= 1'b0; pull_down_en_o <= 1'b0; busy_o <= 1'b1; end
        default: begin pull_up_en_o <= 1'b0; pull_down_en_o <= 1'b0; busy_o <= 1'b0; end
      endcase
    end
  end

  a_never_both : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pull_up_en_o && pull_down_en_o));
  a_busy_off : assert property (@(posedge clk_i) disable iff (!rst_ni)
    busy_o |-> (!pull_up_en_o && !pull_down_en_o));

endmodule

// File: tb/tb_phy_pp_drv_ctrl.sv
// tb/tb_phy_pp_drv_ctrl.sv - directed and random checks of phy_pp_drv_ctrl against a reference model
module tb_phy_pp_drv_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       drive_en_i = 1'b0;
  logic       data_i = 1'b0;
  logic       od_mode_i = 1'b0;
  logic [3:0] dead_cycles_i = 4'd0;
  logic       pull_up_en_o, pull_down_en_o, busy_o;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: line direction plus remaining gap cycles.
  logic [1:0] m_out = 2'b00;
  int         m_gap = 0;

  always #5 clk_i = ~clk_i;

  phy_pp_drv_ctrl #(.DeadTimeW(4)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .drive_en_i     (drive_en_i),
    .data_i         (data_i),
    .od_mode_i      (od_mode_i),
    .dead_cycles_i  (dead_cycles_i),
    .pull_up_en_o   (pull_up_en_o),
    .pull_down_en_o (pull_down_en_o),
    .busy_o         (busy_o)
  );

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {pu,pd,busy}=%b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] dut_out();
    return {pull_up_en_o, pull_down_en_o, busy_o};
  endfunction

  function automatic logic [2:0] model_out();
    return {m_out, (m_gap > 0)};
  endfunction

  // Advances the model by one clock edge using the inputs the DUT sees at that edge.
  task automatic model_edge();
    logic [1:0] t;
    if (!drive_en_i)  t = 2'b00;
    else if (!data_i) t = 2'b01;
    else if (od_mode_i) t = 2'b00;
    else t = 2'b10;
    if (m_gap > 0) begin
      if (t == 2'b00) begin
        m_gap = 0;
        m_out = 2'b00;
      end else begin
        m_gap = m_gap - 1;
        if (m_gap == 0) m_out = t;
      end
    end else if (m_out == 2'b00) begin
      m_out = t;
    end else if (t == 2'b00) begin
      m_out = 2'b00;
    end else if (t != m_out) begin
      if (dead_cycles_i == 0) m_out = t;
      else begin
        m_gap = int'(dead_cycles_i);
        m_out = 2'b00;
      end
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
  endtask

  task automatic step_chk(input string tag, input logic [2:0] exp);
    step();
    chk(tag, dut_out(), exp);
  endtask

  initial begin
    // Test 1: reset state, then asynchronous reset while driving high
    #2;
    chk("reset_state", dut_out(), 3'b000);
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive_en_i = 1'b1; data_i = 1'b1; od_mode_i = 1'b0; dead_cycles_i = 4'd3;
    step_chk("t1_high", 3'b100);
    #2 rst_ni = 1'b0;
    #1 chk("t1_async_rst", dut_out(), 3'b000);
    m_out = 2'b00; m_gap = 0;
    @(negedge clk_i);
    drive_en_i = 1'b0;
    rst_ni = 1'b1;
    step_chk("t1_after_rel", 3'b000);

    // Test 2: dead=3 push-pull high->low
    drive_en_i = 1'b1; data_i = 1'b1; dead_cycles_i = 4'd3;
    step_chk("t2_high", 3'b100);
    data_i = 1'b0;
    for (int i = 0; i < 3; i++) step_chk("t2_gap", 3'b001);
    step_chk("t2_low", 3'b010);

    // Test 3: dead=0 direct swaps every cycle
    dead_cycles_i = 4'd0;
    for (int i = 0; i < 6; i++) begin
      data_i = ~data_i;
      step_chk("t3_swap", data_i ? 3'b100 : 3'b010);
    end

    // Test 4: open-drain low then release
    od_mode_i = 1'b1; data_i = 1'b0;
    step_chk("t4_od_low", 3'b010);
    data_i = 1'b1;
    step_chk("t4_od_rel", 3'b000);
    step_chk("t4_od_rel2", 3'b000);

    // Test 5: dead=5 gap aborted by release on second gap cycle
    od_mode_i = 1'b0; dead_cycles_i = 4'd5;
    step_chk("t5_high", 3'b100);
    data_i = 1'b0;
    step_chk("t5_gap1", 3'b001);
    step_chk("t5_gap2", 3'b001);
    drive_en_i = 1'b0;
    step_chk("t5_abort", 3'b000);

    // Test 6: dead=4 with target reverting mid-gap still runs full gap
    drive_en_i = 1'b1; data_i = 1'b1; dead_cycles_i = 4'd4;
    step_chk("t6_high", 3'b100);
    data_i = 1'b0;
    step_chk("t6_gap1", 3'b001);
    data_i = 1'b1;
    dead_cycles_i = 4'd9;
    for (int i = 0; i < 3; i++) step_chk("t6_gap", 3'b001);
    step_chk("t6_exit_high", 3'b100);

    // Random: compare against the model every cycle
    for (int i = 0; i < 3000; i++) begin
      drive_en_i    = ($urandom_range(0, 7) != 0);
      data_i        = ($urandom_range(0, 3) == 0) ? ~data_i : data_i;
      od_mode_i     = ($urandom_range(0, 15) == 0) ? ~od_mode_i : od_mode_i;
      dead_cycles_i = 4'($urandom_range(0, 5));
      step();
      chk("rand_model", dut_out(), model_out());
      if (pull_up_en_o && pull_down_en_o) chk("rand_never11", dut_out(), 3'b000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
